ray_sphere_discriminant: RTL and testbench

//  Upstream stage of the sphere-distance path. Takes one ray (origin, direction) and one

---
 rtl/ray_sphere_discriminant.sv | 218 +++++++++++++++++++++
 tb/tb_ray_sphere_discriminant.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_discriminant.sv
// Ray/sphere quadratic terms: B = 2*(D.L), disc sign test and floor(sqrt(disc))
// computed by a fixed-latency restoring bit-serial square root.
module ray_sphere_discriminant #(
  parameter int COORD_W = 16,
  parameter int ROOT_W  = 16,
  parameter int B_W     = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      InputValid,
  output logic                      InputReady,
  input  logic signed [COORD_W-1:0] OriginX,
  input  logic signed [COORD_W-1:0] OriginY,
  input  logic signed [COORD_W-1:0] OriginZ,
  input  logic signed [COORD_W-1:0] DirX,
  input  logic signed [COORD_W-1:0] DirY,
  input  logic signed [COORD_W-1:0] DirZ,
  input  logic signed [COORD_W-1:0] CentreX,
  input  logic signed [COORD_W-1:0] CentreY,
  input  logic signed [COORD_W-1:0] CentreZ,
  input  logic signed [COORD_W-1:0] Radius,
  output logic                      OutputValid,
  input  logic                      OutputAccept,
  output logic signed [B_W-1:0]     B,
  output logic [ROOT_W-1:0]         RootDiscriminant,
  output logic                      QuickIntersects,
  output logic                      Overflow
);

  localparam int LW = COORD_W + 1;
  localparam int PW = 2*COORD_W + 4;
  localparam int DW = 4*COORD_W + 8;
  localparam int RW = 2*ROOT_W;
  localparam int CW = $clog2(ROOT_W + 1);
  localparam logic signed [PW-1:0] B_MAX = {{(PW-B_W+1){1'b0}}, {(B_W-1){1'b1}}};
  localparam logic signed [PW-1:0] B_MIN = ~B_MAX;

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_DOT, S_DISC, S_SQRT, S_DONE} state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d, valid_q, valid_d;
  logic signed [COORD_W-1:0] o_q [3], o_d [3], dir_q [3], dir_d [3], c_q [3], c_d [3];
  logic signed [COORD_W-1:0] r_q, r_d;
  logic signed [LW-1:0] l_q [3], l_d [3];
  logic signed [PW-1:0] a_q, a_d, dl_q, dl_d, ll_q, ll_d, r2_q, r2_d;
  logic signed [B_W-1:0] bsat_q, bsat_d, b_out_q, b_out_d;
  logic bovf_q, bovf_d, rsat_q, rsat_d, qi_q, qi_d;
  logic [RW-1:0] rad_q, rad_d;
  logic [ROOT_W:0] rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d, root_out_q, root_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qi_out_q, qi_out_d, ovf_out_q, ovf_out_d;

  logic signed [PW-1:0] bfull, cq;
  logic signed [DW-1:0] disc;
  logic [ROOT_W+2:0] rem_t, trial;

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    o_d        = o_q;
    dir_d      = dir_q;
    c_d        = c_q;
    r_d        = r_q;
    l_d        = l_q;
    a_d        = a_q;
    dl_d       = dl_q;
    ll_d       = ll_q;
    r2_d       = r2_q;
    bsat_d     = bsat_q;
    bovf_d     = bovf_q;
    rsat_d     = rsat_q;
    qi_d       = qi_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    b_out_d    = b_out_q;
    root_out_d = root_out_q;
    qi_out_d   = qi_out_q;
    ovf_out_d  = ovf_out_q;

    bfull = dl_q <<< 1;
    cq    = ll_q - r2_q;
    disc  = DW'(bfull) * DW'(bfull) - DW'(4) * DW'(a_q) * DW'(cq);
    rem_t = {rem_q, rad_q[RW-1 -: 2]};
    trial = {1'b0, root_q, 2'b01};

    case (state_q)
      S_IDLE: begin
        if (InputValid && ready_q) begin
          o_d     = '{OriginX, OriginY, OriginZ};
          dir_d   = '{DirX, DirY, DirZ};
          c_d     = '{CentreX, CentreY, CentreZ};
          r_d     = Radius;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        for (int unsigned i = 0; i < 3; i++)
          l_d[i] = LW'(o_q[i]) - LW'(c_q[i]);
        state_d = S_DOT;
      end
      S_DOT: begin
        a_d  = '0;
        dl_d = '0;
        ll_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
          a_d  = a_d  + PW'(dir_q[i]) * PW'(dir_q[i]);
          dl_d = dl_d + PW'(dir_q[i]) * PW'(l_q[i]);
          ll_d = ll_d + PW'(l_q[i])   * PW'(l_q[i]);
        end
        r2_d    = PW'(r_q) * PW'(r_q);
        state_d = S_DISC;
      end
      S_DISC: begin
        if (bfull > B_MAX) begin
          bsat_d = {1'b0, {(B_W-1){1'b1}}};
          bovf_d = 1'b1;
        end else if (bfull < B_MIN) begin
          bsat_d = {1'b1, {(B_W-1){1'b0}}};
          bovf_d = 1'b1;
        end else begin
          bsat_d = bfull[B_W-1:0];
          bovf_d = 1'b0;
        end
        // Out-of-range radicands still run the full iteration count for fixed latency.
        qi_d   = ~disc[DW-1];
        rsat_d = ~disc[DW-1] & (|disc[DW-2:RW]);
        rad_d  = (disc[DW-1] || (|disc[DW-2:RW])) ? '0 : disc[RW-1:0];
        rem_d  = '0;
        root_d = '0;
        cnt_d  = CW'(ROOT_W - 1);
        state_d = S_SQRT;
      end
      S_SQRT: begin
        rad_d = rad_q << 2;
        if (rem_t >= trial) begin
          rem_d  = (ROOT_W+1)'(rem_t - trial);
          root_d = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
          rem_d  = rem_t[ROOT_W:0];
          root_d = {root_q[ROOT_W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          b_out_d    = bsat_q;
          root_out_d = rsat_q ? '1 : root_d;
          qi_out_d   = qi_q;
          ovf_out_d  = bovf_q | rsat_q;
          valid_d    = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (OutputAccept) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && state_d == S_IDLE) ready_d = 1'b1;
    if (state_d != S_IDLE) ready_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      b_out_q    <= '0;
      root_out_q <= '0;
      qi_out_q   <= 1'b0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      b_out_q    <= b_out_d;
      root_out_q <= root_out_d;
      qi_out_q   <= qi_out_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  always_ff @(posedge CLK) begin
    o_q    <= o_d;
    dir_q  <= dir_d;
    c_q    <= c_d;
    r_q    <= r_d;
    l_q    <= l_d;
    a_q    <= a_d;
    dl_q   <= dl_d;
    ll_q   <= ll_d;
    r2_q   <= r2_d;
    bsat_q <= bsat_d;
    bovf_q <= bovf_d;
    rsat_q <= rsat_d;
    qi_q   <= qi_d;
    rad_q  <= rad_d;
    rem_q  <= rem_d;
    root_q <= root_d;
    cnt_q  <= cnt_d;
  end

  assign InputReady       = ready_q;
  assign OutputValid      = valid_q;
  assign B                = b_out_q;
  assign RootDiscriminant = root_out_q;
  assign QuickIntersects  = qi_out_q;
  assign Overflow         = ovf_out_q;

endmodule

// File: tb/tb_ray_sphere_discriminant.sv
// Bench for ray_sphere_discriminant: directed cases, stall, back-to-back,
// mid-job reset and random jobs against a wide-integer arithmetic model.
module tb_ray_sphere_discriminant;

  typedef struct packed {
    logic signed [15:0] ox, oy, oz, dx, dy, dz, cx, cy, cz, r;
  } job_t;

  typedef struct packed {
    logic [15:0] b;
    logic [15:0] root;
    logic        qi;
    logic        ovf;
  } res_t;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic InputValid = 1'b0;
  logic OutputAccept = 1'b0;
  logic InputReady, OutputValid, QuickIntersects, Overflow;
  logic signed [15:0] OriginX = '0, OriginY = '0, OriginZ = '0;
  logic signed [15:0] DirX = '0, DirY = '0, DirZ = '0;
  logic signed [15:0] CentreX = '0, CentreY = '0, CentreZ = '0, Radius = '0;
  logic signed [15:0] B;
  logic [15:0] RootDiscriminant;

  int total = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  ray_sphere_discriminant #(.COORD_W(16), .ROOT_W(16), .B_W(16)) dut (
    .CLK(CLK), .reset(reset), .InputValid(InputValid), .InputReady(InputReady),
    .OriginX(OriginX), .OriginY(OriginY), .OriginZ(OriginZ),
    .DirX(DirX), .DirY(DirY), .DirZ(DirZ),
    .CentreX(CentreX), .CentreY(CentreY), .CentreZ(CentreZ), .Radius(Radius),
    .OutputValid(OutputValid), .OutputAccept(OutputAccept), .B(B),
    .RootDiscriminant(RootDiscriminant), .QuickIntersects(QuickIntersects),
    .Overflow(Overflow)
  );

  function automatic res_t model(input job_t j);
    logic signed [127:0] lx, ly, lz, dx, dy, dz, a, dl, ll, r2, bf, disc, rr;
    longint unsigned d64, res, cand;
    res_t o;
    lx = j.ox; lx = lx - j.cx;
    ly = j.oy; ly = ly - j.cy;
    lz = j.oz; lz = lz - j.cz;
    dx = j.dx; dy = j.dy; dz = j.dz; rr = j.r;
    a  = dx*dx + dy*dy + dz*dz;
    dl = dx*lx + dy*ly + dz*lz;
    ll = lx*lx + ly*ly + lz*lz;
    r2 = rr*rr;
    bf = 2*dl;
    disc = bf*bf - 4*a*(ll - r2);
    o.ovf = 1'b0;
    if (bf > 32767) begin o.b = 16'h7FFF; o.ovf = 1'b1; end
    else if (bf < -32768) begin o.b = 16'h8000; o.ovf = 1'b1; end
    else o.b = bf[15:0];
    o.qi = (disc >= 0);
    if (disc < 0) o.root = 16'h0;
    else if (disc >= 128'sh1_0000_0000) begin o.root = 16'hFFFF; o.ovf = 1'b1; end
    else begin
      d64 = disc[63:0];
      res = 0;
      for (int k = 15; k >= 0; k--) begin
        cand = res | (64'd1 << k);
        if (cand*cand <= d64) res = cand;
      end
      o.root = res[15:0];
    end
    return o;
  endfunction

  function automatic job_t mk(input int ox, oy, oz, dx, dy, dz, cx, cy, cz, r);
    job_t j;
    j.ox = 16'(ox); j.oy = 16'(oy); j.oz = 16'(oz);
    j.dx = 16'(dx); j.dy = 16'(dy); j.dz = 16'(dz);
    j.cx = 16'(cx); j.cy = 16'(cy); j.cz = 16'(cz); j.r = 16'(r);
    return j;
  endfunction

  function automatic res_t sample();
    res_t s;
    s.b = B; s.root = RootDiscriminant; s.qi = QuickIntersects; s.ovf = Overflow;
    return s;
  endfunction

  // Presents a job and returns once it is accepted (ok=0 if never ready).
  task automatic start(input job_t j, output bit ok);
    int w;
    @(negedge CLK);
    {OriginX, OriginY, OriginZ, DirX, DirY, DirZ, CentreX, CentreY, CentreZ, Radius} = j;
    InputValid = 1'b1;
    w = 0;
    while (!InputReady && w < 100) begin @(negedge CLK); w++; end
    ok = InputReady;
    @(posedge CLK);
    @(negedge CLK);
    InputValid = 1'b0;
  endtask

  // Issues a job and waits for OutputValid; lat = -1 on timeout.
  task automatic issue(input job_t j, output int lat);
    bit ok;
    start(j, ok);
    lat = 0;
    while (!OutputValid && lat < 200) begin @(negedge CLK); lat++; end
    if (!ok || !OutputValid) lat = -1;
  endtask

  task automatic take();
    OutputAccept = 1'b1;
    @(negedge CLK);
    OutputAccept = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({InputReady, OutputValid, B, RootDiscriminant, QuickIntersects, Overflow} !== '0)
      $display("FAIL reset_state: ready=%b valid=%b B=%h root=%h qi=%b ovf=%b, required all 0",
               InputReady, OutputValid, B, RootDiscriminant, QuickIntersects, Overflow);
    else passed++;
    reset = 1'b0;
    @(negedge CLK);
    total++;
    if (InputReady !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", InputReady);
    else passed++;
  endtask

  task automatic test_directed();
    job_t jobs [5];
    res_t want [5];
    res_t got;
    int lat;
    jobs[0] = mk(0, 0, -10, 0, 0, 1, 0, 0, 0, 2);          want[0] = '{16'hFFEC, 16'd4, 1'b1, 1'b0};
    jobs[1] = mk(0, 10, 0, 0, -1, 0, 10, -10, 10, 2);      want[1] = '{16'hFFD8, 16'd0, 1'b0, 1'b0};
    jobs[2] = mk(0, 0, 0, 1, 1, 0, 10, 10, 0, 3);          want[2] = '{16'hFFD8, 16'd8, 1'b1, 1'b0};
    jobs[3] = mk(0, 0, -30000, 0, 0, 100, 0, 0, 0, 1);     want[3] = '{16'h8000, 16'd200, 1'b1, 1'b1};
    jobs[4] = mk(0, 0, -30000, 0, 0, 2, 0, 0, 0, 30000);   want[4] = '{16'h8000, 16'hFFFF, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(jobs[i], lat);
      got = sample();
      total++;
      if (lat !== 19) $display("FAIL directed%0d_latency: got %0d required 19", i, lat);
      else passed++;
      total++;
      if (got !== want[i])
        $display("FAIL directed%0d_result: got B=%h root=%h qi=%b ovf=%b required B=%h root=%h qi=%b ovf=%b",
                 i, got.b, got.root, got.qi, got.ovf, want[i].b, want[i].root, want[i].qi, want[i].ovf);
      else passed++;
      take();
    end
  endtask

  task automatic test_stall();
    res_t held, now;
    int lat;
    issue(mk(0, 0, 0, 1, 1, 0, 10, 10, 0, 3), lat);
    held = sample();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      now = sample();
      total++;
      if (now !== held || InputReady !== 1'b0 || OutputValid !== 1'b1)
        $display("FAIL stall_hold%0d: B=%h root=%h ready=%b valid=%b required B=%h root=%h ready=0 valid=1",
                 i, now.b, now.root, InputReady, OutputValid, held.b, held.root);
      else passed++;
    end
    take();
    total++;
    if (InputReady !== 1'b1 || OutputValid !== 1'b0)
      $display("FAIL stall_release: ready=%b valid=%b required ready=1 valid=0", InputReady, OutputValid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    job_t jobs [2];
    res_t got, want;
    int lat;
    jobs[0] = mk(0, 0, -10, 0, 0, 1, 0, 0, 0, 2);
    jobs[1] = mk(0, 0, 0, 1, 1, 0, 10, 10, 0, 3);
    OutputAccept = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(jobs[i], lat);
      got = sample();
      want = model(jobs[i]);
      total++;
      if (lat !== 19 || got !== want)
        $display("FAIL b2b%0d: lat=%0d B=%h root=%h qi=%b required lat=19 B=%h root=%h qi=%b",
                 i, lat, got.b, got.root, got.qi, want.b, want.root, want.qi);
      else passed++;
    end
    @(negedge CLK);
    OutputAccept = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rises, lat;
    res_t got, want;
    job_t j;
    j = mk(0, 0, -10, 0, 0, 1, 0, 0, 0, 2);
    start(j, ok);
    repeat (7) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    total++;
    if (InputReady !== 1'b0 || OutputValid !== 1'b0)
      $display("FAIL midreset_during: ready=%b valid=%b required 0 0", InputReady, OutputValid);
    else passed++;
    @(negedge CLK);
    total++;
    if (InputReady !== 1'b1) $display("FAIL midreset_ready: got %b required 1", InputReady);
    else passed++;
    rises = 0;
    repeat (30) begin @(negedge CLK); if (OutputValid) rises++; end
    total++;
    if (rises != 0 || !ok) $display("FAIL midreset_novalid: valid cycles %0d required 0", rises);
    else passed++;
    issue(j, lat);
    got = sample();
    want = model(j);
    total++;
    if (lat !== 19 || got !== want)
      $display("FAIL midreset_next: lat=%0d B=%h root=%h required lat=19 B=%h root=%h",
               lat, got.b, got.root, want.b, want.root);
    else passed++;
    take();
  endtask

  task automatic test_random();
    job_t j;
    res_t got, want;
    int lat, v [10], span;
    for (int n = 0; n < 40; n++) begin
      span = (n % 3 == 0) ? 32767 : ((n % 3 == 1) ? 100 : 2000);
      for (int k = 0; k < 10; k++) v[k] = $urandom_range(0, 2*span) - span;
      j = mk(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8], v[9]);
      issue(j, lat);
      got = sample();
      want = model(j);
      total++;
      if (lat !== 19 || got !== want)
        $display("FAIL random%0d: lat=%0d B=%h root=%h qi=%b ovf=%b required lat=19 B=%h root=%h qi=%b ovf=%b",
                 n, lat, got.b, got.root, got.qi, got.ovf, want.b, want.root, want.qi, want.ovf);
      else passed++;
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
      take();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
